// File: rtl/uart_pkg.sv
// Shared types and constants for the scheduled UART transmitter.
// Holds the framing state encoding and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_STOP_BITS = 1;

    // Line time of one frame, in baud ticks.
    function automatic int frame_ticks(input int data_w, input int parity_en, input int stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_grant,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin shared UART transmitter: arbitrates byte requesters and
// serialises the winner's byte as start/data/parity/stop, paced by tx_enb.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = DEF_STOP_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tx_enb,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic               stop_cnt;
    logic [IDX_W-1:0]   last_grant;
    logic [DATA_W-1:0]  shift;
    logic               parity;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [DATA_W-1:0]  win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (win_onehot),
        .grant_idx  (win_idx),
        .any        (win_any)
    );

    assign req_ready = (state == ST_IDLE) ? win_onehot : '0;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Framing control; a baud tick arriving in the grant cycle is deliberately not consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_id   <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        grant_id   <= win_idx;
                        last_grant <= win_idx;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tx_enb) begin
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_enb) begin
                        tx      <= shift[0];
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_enb) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity;
                                state <= ST_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                        end else begin
                            tx      <= shift[0];
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tx_enb) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tx_enb) begin
                        if (stop_cnt == LAST_STOP) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: shift register consumed LSB-first; parity taken from the whole byte at latch time.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && win_any) begin
            shift  <= win_data;
            parity <= ^win_data;
        end else if (tx_enb && (state == ST_START || state == ST_DATA)) begin
            shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed table, hand-written corner sequences and
// randomized traffic against a frame-level reference model.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_enb;
    logic [3:0]  valid;
    logic [31:0] data;
    int          sel;

    logic [3:0] valid_d, valid_p, ready_d, ready_p, m_ready;
    logic       tx_d, tx_p, busy_d, busy_p, done_d, done_p, m_tx, m_busy, m_done;
    logic [1:0] gid_d, gid_p, m_gid;

    int checks = 0;
    int errors = 0;
    int lg[2];
    int ph;

    assign valid_d = (sel == 0) ? valid : 4'b0;
    assign valid_p = (sel == 1) ? valid : 4'b0;
    assign m_ready = (sel == 0) ? ready_d : ready_p;
    assign m_tx    = (sel == 0) ? tx_d    : tx_p;
    assign m_busy  = (sel == 0) ? busy_d  : busy_p;
    assign m_done  = (sel == 0) ? done_d  : done_p;
    assign m_gid   = (sel == 0) ? gid_d   : gid_p;

    uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .PARITY_EN(0), .STOP_BITS(1)) dut_d (
        .clk(clk), .rst(rst), .tx_enb(tx_enb), .req_valid(valid_d), .req_data(data),
        .req_ready(ready_d), .tx(tx_d), .busy(busy_d), .grant_id(gid_d), .done(done_d)
    );

    uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
        .clk(clk), .rst(rst), .tx_enb(tx_enb), .req_valid(valid_p), .req_data(data),
        .req_ready(ready_p), .tx(tx_p), .busy(busy_p), .grant_id(gid_p), .done(done_p)
    );

    always #5 clk = ~clk;

    // Baud tick every 4 clk, changed just after the rising edge.
    initial begin
        tx_enb = 1'b0;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            tx_enb = (ph == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=still_running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (!valid[i]) data[i*8 +: 8] = 8'($urandom);
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    task automatic wait_ticks(input int n);
        int cnt;
        bit en;
        cnt = 0;
        for (int c = 0; c < 8 * n + 8 && cnt < n; c++) begin
            en = tx_enb;
            step();
            if (en) cnt++;
        end
        chk("tick_count", cnt, n);
    endtask

    // Expected line: start, data LSB-first, optional even parity, stop bits; done on the tick ending the last stop bit.
    task automatic expect_frame(input int id, input logic [7:0] b, input bit keep, input int budget, output bit coinc);
        int n, p, s;
        logic [1:0] exp_q[$];
        logic [1:0] e;
        logic prev;
        bit en, hit;
        #1;
        n = 0;
        while (m_ready == 4'b0 && n < budget) begin
            step();
            n++;
        end
        chk("ready_onehot", m_ready, 32'(1 << id));
        coinc = tx_enb;
        if (m_ready == 4'b0) return;
        step();
        if (!keep) valid[id] = 1'b0;
        chk("busy_after_grant", m_busy, 1);
        chk("grant_id", m_gid, id);
        chk("tx_idle_in_load", m_tx, 1);
        chk("ready_single_pulse", m_ready, 0);
        p = sel;
        s = (sel == 1) ? 2 : 1;
        exp_q = {};
        exp_q.push_back(2'b00);
        for (int i = 0; i < 8; i++) exp_q.push_back({b[i], 1'b0});
        if (p != 0) exp_q.push_back({^b, 1'b0});
        for (int j = 0; j < s; j++) exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
        prev = 1'b1;
        while (exp_q.size() > 0) begin
            hit = 1'b0;
            for (int c = 0; c < 8 && !hit; c++) begin
                en = tx_enb;
                step();
                if (en) hit = 1'b1;
                else begin
                    chk("tx_hold", m_tx, prev);
                    chk("done_low", m_done, 0);
                    chk("ready_low", m_ready, 0);
                end
            end
            chk("tick_seen", hit, 1);
            e = exp_q.pop_front();
            chk("tx_bit", m_tx, e[1]);
            chk("done_pulse", m_done, e[0]);
            prev = e[1];
            if (exp_q.size() > 0) chk("busy_mid", m_busy, 1);
            else chk("busy_with_done", m_busy, 0);
        end
    endtask

    typedef struct {
        bit         rst_before;
        int         sel;
        logic [3:0] raise;
        logic [31:0] wdata;
        bit         keep;
        bit         b2b;
        int         exp_id;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit co;
        int w, r;
        logic [7:0] b;
        bit keep;

        tbl[0]  = '{0, 0, 4'b0100, 32'h00A50000, 0, 0, 2, 8'hA5};
        tbl[1]  = '{1, 0, 4'b1111, 32'h44332211, 0, 0, 0, 8'h11};
        tbl[2]  = '{0, 0, 4'b0000, 32'h0,        0, 1, 1, 8'h22};
        tbl[3]  = '{0, 0, 4'b0000, 32'h0,        0, 1, 2, 8'h33};
        tbl[4]  = '{0, 0, 4'b0000, 32'h0,        0, 1, 3, 8'h44};
        tbl[5]  = '{0, 1, 4'b0001, 32'h00000007, 0, 0, 0, 8'h07};
        tbl[6]  = '{0, 0, 4'b1001, 32'h3C0000C3, 1, 0, 0, 8'hC3};
        tbl[7]  = '{0, 0, 4'b0000, 32'h0,        1, 1, 3, 8'h3C};
        tbl[8]  = '{0, 0, 4'b0000, 32'h0,        1, 1, 0, 8'hC3};
        tbl[9]  = '{0, 0, 4'b0010, 32'h00005A00, 0, 1, 1, 8'h5A};
        tbl[10] = '{0, 0, 4'b0000, 32'h0,        1, 1, 3, 8'h3C};
        tbl[11] = '{0, 0, 4'b0000, 32'h0,        0, 1, 0, 8'hC3};
        tbl[12] = '{0, 0, 4'b0000, 32'h0,        0, 1, 3, 8'h3C};

        rst = 1'b1;
        valid = 4'b0;
        data = 32'h0;
        sel = 0;
        step();
        step();
        #1;
        chk("rst_tx", tx_d, 1);
        chk("rst_busy", busy_d, 0);
        chk("rst_done", done_d, 0);
        chk("rst_ready", ready_d, 0);
        chk("rst_gid", gid_d, 0);
        chk("rst_tx_p", tx_p, 1);
        chk("rst_busy_p", busy_p, 0);
        rst = 1'b0;
        lg[0] = 3;
        lg[1] = 3;
        step();

        for (int t = 0; t < 13; t++) begin
            if (tbl[t].rst_before) begin
                rst = 1'b1;
                step();
                step();
                rst = 1'b0;
                lg[0] = 3;
                lg[1] = 3;
                step();
            end
            sel = tbl[t].sel;
            for (int i = 0; i < 4; i++)
                if (tbl[t].raise[i]) begin
                    valid[i] = 1'b1;
                    data[i*8 +: 8] = tbl[t].wdata[i*8 +: 8];
                end
            expect_frame(tbl[t].exp_id, tbl[t].exp_byte, tbl[t].keep, tbl[t].b2b ? 0 : 20, co);
            lg[sel] = tbl[t].exp_id;
            if (t == 0) begin
                step();
                chk("done_one_cycle", m_done, 0);
            end
        end

        // Grant cycle coincides with a tick: start bit must wait for the next tick.
        sel = 0;
        for (int c = 0; c < 8 && !tx_enb; c++) step();
        valid[2] = 1'b1;
        data[23:16] = 8'h96;
        expect_frame(2, 8'h96, 0, 0, co);
        chk("coincident_tick", co, 1);
        lg[0] = 2;

        // Reset during data bit 4 aborts the frame.
        valid[1] = 1'b1;
        data[15:8] = 8'h0F;
        #1;
        chk("abort_ready", m_ready, 4'b0010);
        step();
        valid[1] = 1'b0;
        wait_ticks(6);
        chk("abort_bit4", m_tx, 0);
        step();
        rst = 1'b1;
        #1;
        chk("abort_tx", m_tx, 1);
        chk("abort_busy", m_busy, 0);
        chk("abort_done", m_done, 0);
        chk("abort_gid", m_gid, 0);
        step();
        step();
        rst = 1'b0;
        lg[0] = 3;
        lg[1] = 3;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("abort_no_done", m_done, 0);
            chk("abort_line_idle", m_tx, 1);
        end
        valid[0] = 1'b1;
        data[7:0] = 8'hE1;
        valid[2] = 1'b1;
        data[23:16] = 8'h4B;
        expect_frame(0, 8'hE1, 0, 0, co);
        expect_frame(2, 8'h4B, 0, 0, co);
        lg[0] = 2;

        // Randomized traffic on both configurations.
        for (int sv = 0; sv < 2; sv++) begin
            sel = sv;
            for (int f = 0; f < 18; f++) begin
                for (int i = 0; i < 4; i++)
                    if (valid[i] && $urandom_range(0, 5) == 0) valid[i] = 1'b0;
                for (int i = 0; i < 4; i++)
                    if (!valid[i] && $urandom_range(0, 1) == 1) begin
                        valid[i] = 1'b1;
                        data[i*8 +: 8] = 8'($urandom);
                    end
                if (valid == 4'b0) begin
                    r = $urandom_range(0, 3);
                    valid[r] = 1'b1;
                    data[r*8 +: 8] = 8'($urandom);
                end
                w = rr_pick(valid, lg[sel]);
                b = data[w*8 +: 8];
                keep = 1'($urandom_range(0, 1));
                expect_frame(w, b, keep, 0, co);
                lg[sel] = w;
            end
            valid = 4'b0;
            step();
            step();
            chk("idle_after_random", m_busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
